// File: rtl/img_sub_pkg.sv
// Shared types and constants for the image-subtraction arbiter.
// The FSM state encoding and the fixed transaction lengths live here.
package img_sub_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_RES = 2'd2,
    DRAIN    = 2'd3
  } state_e;

  // Pixel beats fed to the engine per transaction.
  localparam int IMG_BEATS  = 18;
  // Result beats returned by the engine per transaction.
  localparam int DIFF_BEATS = 9;

endpackage

// File: rtl/img_sub_arb_rr_arb2.sv
// Two-way round-robin grant selection.
// ptr = 0 prefers requester A (bit 0), ptr = 1 prefers requester B (bit 1).
// The preferred requester wins if it requests, otherwise the other one does.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // One-hot pick of the preferred requester, falling back to the other one.
  always_comb begin
    gnt = 2'b00;
    case ({ptr, req})
      3'b0_01, 3'b0_11: gnt = 2'b01;
      3'b0_10:          gnt = 2'b10;
      3'b1_10, 3'b1_11: gnt = 2'b10;
      3'b1_01:          gnt = 2'b01;
      default:          gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/img_sub_arb.sv
// Arbiter sharing one subtraction engine between two pixel requesters.
// A transaction is: grant -> 18 forwarded pixel beats -> wait for the engine
// -> 9 forwarded result beats -> back to idle with the round-robin pointer
// flipped to the requester that was not served.
// Optional feature: define IMG_SUB_ARB_TIMEOUT_EN to abandon a grant whose
// owner sends no beat at all within TIMEOUT_CYC cycles.
import img_sub_pkg::*;

module img_sub_arb #(
  parameter int TIMEOUT_CYC = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       in_valid_a,
  input  logic [3:0] in_image_a,
  input  logic       in_valid_b,
  input  logic [3:0] in_image_b,
  output logic [1:0] grant,
  output logic       sub_in_valid,
  output logic [3:0] sub_in_image,
  input  logic       sub_out_valid,
  input  logic [3:0] sub_out_diff,
  output logic       out_valid,
  output logic [3:0] out_diff,
  output logic       out_id
);

  localparam logic [4:0] LAST_BEAT = 5'(IMG_BEATS - 1);
  localparam logic [3:0] LAST_RES  = 4'(DIFF_BEATS - 1);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_e     state_r;
  state_e     nxt_state_s;
  logic [1:0] grant_r;
  logic       served_r;      // 0 = A, 1 = B; survives grant drop for out_id
  logic       rr_ptr_r;      // 0 = A preferred
  logic [4:0] beat_cnt_r;
  logic [3:0] res_cnt_r;
  logic       sub_in_valid_r;
  logic [3:0] sub_in_image_r;
  logic       out_valid_r;
  logic [3:0] out_diff_r;
  logic       out_id_r;

  logic [1:0] rr_gnt_s;
  logic       gnt_valid_s;
  logic [3:0] gnt_image_s;
  logic       beat_fire_s;
  logic       res_fire_s;
  logic       release_s;     // transaction ends; flip the pointer

`ifdef IMG_SUB_ARB_TIMEOUT_EN
  localparam int             TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt_r;
`endif

  rr_arb2 u_rr_arb2 (
    .req (req),
    .ptr (rr_ptr_r),
    .gnt (rr_gnt_s)
  );

  // Select the beat of the current grant owner; other requester is ignored.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_image_s = 4'h0;
    case (grant_r)
      2'b01: begin
        gnt_valid_s = in_valid_a;
        gnt_image_s = in_image_a;
      end
      2'b10: begin
        gnt_valid_s = in_valid_b;
        gnt_image_s = in_image_b;
      end
      default: begin
        gnt_valid_s = 1'b0;
        gnt_image_s = 4'h0;
      end
    endcase
  end

  // Next-state logic and per-cycle strobes for beats, results and release.
  always_comb begin
    nxt_state_s = state_r;
    beat_fire_s = 1'b0;
    res_fire_s  = 1'b0;
    release_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req != 2'b00) begin
          nxt_state_s = STREAM;
        end else begin
          nxt_state_s = IDLE;
        end
      end
      STREAM: begin
        if (gnt_valid_s) begin
          beat_fire_s = 1'b1;
          if (beat_cnt_r == LAST_BEAT) begin
            nxt_state_s = WAIT_RES;
          end else begin
            nxt_state_s = STREAM;
          end
        end else begin
`ifdef IMG_SUB_ARB_TIMEOUT_EN
          if ((beat_cnt_r == 5'd0) && (to_cnt_r == TO_LAST)) begin
            nxt_state_s = IDLE;
            release_s   = 1'b1;
          end else begin
            nxt_state_s = STREAM;
          end
`else
          nxt_state_s = STREAM;
`endif
        end
      end
      WAIT_RES: begin
        // The first result both opens the drain and is forwarded itself.
        if (sub_out_valid) begin
          res_fire_s  = 1'b1;
          nxt_state_s = DRAIN;
        end else begin
          nxt_state_s = WAIT_RES;
        end
      end
      DRAIN: begin
        if (sub_out_valid) begin
          res_fire_s = 1'b1;
          if (res_cnt_r == LAST_RES) begin
            nxt_state_s = IDLE;
            release_s   = 1'b1;
          end else begin
            nxt_state_s = DRAIN;
          end
        end else begin
          nxt_state_s = DRAIN;
        end
      end
      default: begin
        nxt_state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= nxt_state_s;
    end
  end

  // Grant, pointer, counters and registered engine/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_r        <= 2'b00;
      served_r       <= 1'b0;
      rr_ptr_r       <= 1'b0;
      beat_cnt_r     <= 5'd0;
      res_cnt_r      <= 4'd0;
      sub_in_valid_r <= 1'b0;
      sub_in_image_r <= 4'h0;
      out_valid_r    <= 1'b0;
      out_diff_r     <= 4'h0;
      out_id_r       <= 1'b0;
    end else begin
      if ((state_r == IDLE) && (nxt_state_s == STREAM)) begin
        grant_r  <= rr_gnt_s;
        served_r <= rr_gnt_s[1];
      end else if ((state_r == STREAM) && (nxt_state_s != STREAM)) begin
        grant_r  <= 2'b00;
      end else begin
        grant_r  <= grant_r;
      end

      if (release_s) begin
        rr_ptr_r <= ~served_r;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end

      if (state_r == IDLE) begin
        beat_cnt_r <= 5'd0;
      end else if (beat_fire_s) begin
        beat_cnt_r <= beat_cnt_r + 5'd1;
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end

      if (state_r == IDLE) begin
        res_cnt_r <= 4'd0;
      end else if (res_fire_s) begin
        res_cnt_r <= res_cnt_r + 4'd1;
      end else begin
        res_cnt_r <= res_cnt_r;
      end

      sub_in_valid_r <= beat_fire_s;
      sub_in_image_r <= beat_fire_s ? gnt_image_s : 4'h0;
      out_valid_r    <= res_fire_s;
      out_diff_r     <= res_fire_s ? sub_out_diff : 4'h0;
      out_id_r       <= res_fire_s ? served_r : 1'b0;
    end
  end

`ifdef IMG_SUB_ARB_TIMEOUT_EN
  // Count consecutive silent cycles of the grant owner while streaming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r <= '0;
    end else begin
      if (state_r != STREAM) begin
        to_cnt_r <= '0;
      end else if (gnt_valid_s) begin
        to_cnt_r <= '0;
      end else begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end
    end
  end
`endif

  assign grant        = grant_r;
  assign sub_in_valid = sub_in_valid_r;
  assign sub_in_image = sub_in_image_r;
  assign out_valid    = out_valid_r;
  assign out_diff     = out_diff_r;
  assign out_id       = out_id_r;

endmodule

// File: tb/tb_img_sub_arb.sv
// Self-checking bench for img_sub_arb. A transaction-level model predicts
// which requester wins (round-robin preference), what the engine must see
// one cycle after each granted beat, and what must appear on the result port.
// With IMG_SUB_ARB_TIMEOUT_EN defined the silent-grant timeout is exercised,
// otherwise an indefinitely long silent grant is checked to survive.
module tb_img_sub_arb;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic       in_valid_a;
  logic [3:0] in_image_a;
  logic       in_valid_b;
  logic [3:0] in_image_b;
  logic [1:0] grant;
  logic       sub_in_valid;
  logic [3:0] sub_in_image;
  logic       sub_out_valid;
  logic [3:0] sub_out_diff;
  logic       out_valid;
  logic [3:0] out_diff;
  logic       out_id;

  int checks = 0;
  int errors = 0;

  int         rr_ptr_m = 0;     // model: 0 = A preferred
  logic [3:0] img_pat [18];
  logic [3:0] res_pat [9];
  int         txn_ids [$];

  img_sub_arb #(.TIMEOUT_CYC(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .in_valid_a    (in_valid_a),
    .in_image_a    (in_image_a),
    .in_valid_b    (in_valid_b),
    .in_image_b    (in_image_b),
    .grant         (grant),
    .sub_in_valid  (sub_in_valid),
    .sub_in_image  (sub_in_image),
    .sub_out_valid (sub_out_valid),
    .sub_out_diff  (sub_out_diff),
    .out_valid     (out_valid),
    .out_diff      (out_diff),
    .out_id        (out_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int gid, input logic v, input logic [3:0] d);
    if (gid == 0) begin
      in_valid_a = v;
      in_image_a = d;
    end else begin
      in_valid_b = v;
      in_image_b = d;
    end
  endtask

  task automatic drive_other(input int gid);
    set_beat(1 - gid, 1'($urandom_range(0, 1)), 4'($urandom));
  endtask

  task automatic fill_random();
    for (int i = 0; i < 18; i++) img_pat[i] = 4'($urandom);
    for (int i = 0; i < 9; i++) res_pat[i] = 4'($urandom);
  endtask

  // One full transaction with checks on every cycle.
  task automatic do_txn(input logic [1:0] req_v, input int gap_min, input int gap_max,
                        input int lead_gap, input int mid_gap, input int res_gap,
                        input bit drop_req);
    int         pref;
    int         gid;
    int         ng;
    int         pulses;
    logic [1:0] exp_g;
    logic [1:0] exp_gb;
    logic [13:0] obs;
    logic [13:0] exp;
    pref = rr_ptr_m;
    if (req_v[pref]) gid = pref;
    else gid = 1 - pref;
    exp_g = (gid == 0) ? 2'b01 : 2'b10;

    req = req_v;
    step();
    checks++;
    if (grant !== exp_g) begin
      errors++;
      $display("FAIL grant_start: got %b expected %b", grant, exp_g);
    end
    if (drop_req) req = 2'b00;

    pulses = 0;
    for (int b = 0; b < 18; b++) begin
      ng = $urandom_range(gap_min, gap_max);
      if (b == 0) ng += lead_gap;
      if (b == 1) ng += mid_gap;
      for (int g = 0; g < ng; g++) begin
        set_beat(gid, 1'b0, 4'($urandom));
        drive_other(gid);
        sub_out_valid = 1'($urandom_range(0, 1));
        sub_out_diff  = 4'($urandom);
        step();
        pulses += int'(sub_in_valid);
        obs = {grant, sub_in_valid, sub_in_image, out_valid, out_diff, out_id};
        exp = {exp_g, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0};
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL stream_gap beat %0d: got %h expected %h", b, obs, exp);
        end
      end
      set_beat(gid, 1'b1, img_pat[b]);
      drive_other(gid);
      sub_out_valid = 1'($urandom_range(0, 1));
      sub_out_diff  = 4'($urandom);
      step();
      pulses += int'(sub_in_valid);
      exp_gb = (b == 17) ? 2'b00 : exp_g;
      obs = {grant, sub_in_valid, sub_in_image, out_valid, out_diff, out_id};
      exp = {exp_gb, 1'b1, img_pat[b], 1'b0, 4'h0, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL stream_beat %0d: got %h expected %h", b, obs, exp);
      end
    end
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    checks++;
    if (pulses !== 18) begin
      errors++;
      $display("FAIL beat_count: got %0d expected 18", pulses);
    end

    for (int r = 0; r < 9; r++) begin
      ng = $urandom_range(0, res_gap);
      for (int g = 0; g < ng; g++) begin
        sub_out_valid = 1'b0;
        sub_out_diff  = 4'($urandom);
        in_valid_a = 1'($urandom_range(0, 1));
        in_valid_b = 1'($urandom_range(0, 1));
        step();
        obs = {grant, sub_in_valid, sub_in_image, out_valid, out_diff, out_id};
        exp = 14'h0;
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL result_gap %0d: got %h expected %h", r, obs, exp);
        end
      end
      sub_out_valid = 1'b1;
      sub_out_diff  = res_pat[r];
      in_valid_a = 1'($urandom_range(0, 1));
      in_valid_b = 1'($urandom_range(0, 1));
      step();
      obs = {grant, sub_in_valid, sub_in_image, out_valid, out_diff, out_id};
      exp = {2'b00, 1'b0, 4'h0, 1'b1, res_pat[r], 1'(gid)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL result %0d: got %h expected %h", r, obs, exp);
      end
    end
    sub_out_valid = 1'b0;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    req = 2'b00;
    rr_ptr_m = 1 - gid;
    txn_ids.push_back(gid);
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    rst_n = 1'b0;
    req = 2'b00;
    in_valid_a = 1'b0; in_image_a = 4'h0;
    in_valid_b = 1'b0; in_image_b = 4'h0;
    sub_out_valid = 1'b0; sub_out_diff = 4'h0;
    step();
    step();
    obs = {grant, sub_in_valid, sub_in_image, out_valid, out_diff, out_id};
    checks++;
    if (obs !== 14'h0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs, 14'h0);
    end
    rst_n = 1'b1;
    rr_ptr_m = 0;
    for (int i = 0; i < 3; i++) begin
      sub_out_valid = 1'b1;
      sub_out_diff  = 4'($urandom);
      in_valid_a = 1'b1;
      step();
      obs = {grant, sub_in_valid, sub_in_image, out_valid, out_diff, out_id};
      checks++;
      if (obs !== 14'h0) begin
        errors++;
        $display("FAIL idle_ignore %0d: got %h expected %h", i, obs, 14'h0);
      end
    end
    sub_out_valid = 1'b0;
    in_valid_a = 1'b0;
  endtask

  task automatic test_rr_both();
    int exp_seq [4] = '{0, 1, 0, 1};
    txn_ids.delete();
    for (int t = 0; t < 4; t++) begin
      fill_random();
      do_txn(2'b11, 0, 1, 0, 0, 1, 1'b0);
    end
    for (int t = 0; t < 4; t++) begin
      checks++;
      if (txn_ids[t] !== exp_seq[t]) begin
        errors++;
        $display("FAIL rr_order %0d: got %0d expected %0d", t, txn_ids[t], exp_seq[t]);
      end
    end
  endtask

  task automatic test_single_a();
    for (int i = 0; i < 18; i++) img_pat[i] = 4'((i + 1) % 16);
    for (int i = 0; i < 9; i++) res_pat[i] = 4'(15 - i);
    do_txn(2'b01, 0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_gaps();
    fill_random();
    do_txn(2'b01, 2, 2, 0, 0, 2, 1'b0);
  endtask

  task automatic test_results_b();
    fill_random();
    for (int i = 0; i < 9; i++) res_pat[i] = 4'(15 - i);
    do_txn(2'b10, 0, 1, 0, 0, 3, 1'b1);
  endtask

  task automatic test_random();
    logic [1:0] r;
    for (int t = 0; t < 6; t++) begin
      fill_random();
      r = 2'($urandom_range(1, 3));
      do_txn(r, 0, 3, 0, 0, 3, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] obs;
    req = 2'b01;
    step();
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL rst_mid_grant: got %b expected %b", grant, 2'b01);
    end
    for (int b = 0; b < 10; b++) begin
      in_valid_a = 1'b1;
      in_image_a = 4'(b + 1);
      step();
      checks++;
      if ({sub_in_valid, sub_in_image} !== {1'b1, 4'(b + 1)}) begin
        errors++;
        $display("FAIL rst_mid_beat %0d: got %h expected %h", b,
                 {sub_in_valid, sub_in_image}, {1'b1, 4'(b + 1)});
      end
    end
    rst_n = 1'b0;
    #1;
    obs = {grant, sub_in_valid, sub_in_image, out_valid, out_diff, out_id};
    checks++;
    if (obs !== 14'h0) begin
      errors++;
      $display("FAIL rst_mid_async: got %h expected %h", obs, 14'h0);
    end
    step();
    obs = {grant, sub_in_valid, sub_in_image, out_valid, out_diff, out_id};
    checks++;
    if (obs !== 14'h0) begin
      errors++;
      $display("FAIL rst_mid_edge: got %h expected %h", obs, 14'h0);
    end
    rst_n = 1'b1;
    rr_ptr_m = 0;
    in_valid_a = 1'b0;
    req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      sub_out_valid = 1'b1;
      sub_out_diff  = 4'($urandom);
      step();
      obs = {grant, sub_in_valid, sub_in_image, out_valid, out_diff, out_id};
      checks++;
      if (obs !== 14'h0) begin
        errors++;
        $display("FAIL rst_mid_after %0d: got %h expected %h", i, obs, 14'h0);
      end
    end
    sub_out_valid = 1'b0;
    fill_random();
    do_txn(2'b11, 0, 1, 0, 0, 1, 1'b0);
  endtask

`ifdef IMG_SUB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [1:0] exp_g;
    logic [3:0] obs;
    req = 2'b10;
    step();
    checks++;
    if (grant !== 2'b10) begin
      errors++;
      $display("FAIL timeout_grant: got %b expected %b", grant, 2'b10);
    end
    for (int k = 1; k <= 8; k++) begin
      in_valid_b = 1'b0;
      in_valid_a = 1'($urandom_range(0, 1));
      in_image_a = 4'($urandom);
      sub_out_valid = 1'($urandom_range(0, 1));
      if (k == 3) req = 2'b11;
      step();
      exp_g = (k < 8) ? 2'b10 : 2'b00;
      obs = {grant, sub_in_valid, out_valid};
      checks++;
      if (obs !== {exp_g, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL timeout_cycle %0d: got %b expected %b", k, obs, {exp_g, 2'b00});
      end
    end
    in_valid_a = 1'b0;
    sub_out_valid = 1'b0;
    rr_ptr_m = 0;
    txn_ids.delete();
    fill_random();
    do_txn(2'b11, 0, 1, 0, 0, 1, 1'b0);
    checks++;
    if (txn_ids[0] !== 0) begin
      errors++;
      $display("FAIL timeout_next: got %0d expected 0", txn_ids[0]);
    end
    fill_random();
    do_txn(2'b01, 0, 1, 0, 12, 1, 1'b0);
  endtask
`else
  task automatic test_wait();
    fill_random();
    do_txn(2'b10, 0, 1, 30, 0, 1, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_rr_both();
    test_single_a();
    test_gaps();
    test_results_b();
    test_random();
    test_reset_mid();
`ifdef IMG_SUB_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_wait();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/img_sub_arb.md
IMG_SUB_ARB -- requirements
Module: img_sub_arb

Interface
REQ-001 Parameter TIMEOUT_CYC, default 8, meaning: max idle cycles after grant before first beat (used only with timeout feature).
REQ-002 The block SHALL have one clock and asynchronous, active-low reset: ports clk and rst_n.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  async active-low reset.
REQ-005 req  input  2  per-requester request, level, bit0 = A, bit1 = B.
REQ-006 in_valid_a / in_valid_b  input  1  beat valid from requester A / B.
REQ-007 in_image_a / in_image_b  input  4  pixel nibble from requester A / B.
REQ-008 grant  output  2  one-hot grant, 0 when idle.
REQ-009 sub_in_valid  output  1  beat to subtraction engine.
REQ-010 sub_in_image  output  4  pixel to engine.
REQ-011 sub_out_valid  input  1  engine result valid.
REQ-012 sub_out_diff  input  4  engine result nibble.
REQ-013 out_valid  output  1  forwarded result valid.
REQ-014 out_diff  output  4  forwarded result, 0 when out_valid low.
REQ-015 out_id  output  1  owner of current result (0 = A, 1 = B), 0 when out_valid low.

Function
REQ-016 FSM states SHALL be IDLE, STREAM, WAIT_RES and DRAIN.
REQ-017 IDLE -> STREAM when req != 0: grant the RR-preferred requester if it requests, else the other; grant is registered and stays constant until return to IDLE.
REQ-018 Round-robin pointer SHALL flip to the non-served requester on every DRAIN -> IDLE; reset value prefers A.
REQ-019 In STREAM, each in_valid_x of the granted requester SHALL be forwarded as sub_in_valid/sub_in_image registered, with exactly 1-cycle latency; the non-granted requester's beats are ignored.
REQ-020 Beats need not be contiguous: gaps pass through as sub_in_valid = 0 and sub_in_image = 0.
REQ-021 A 5-bit beat counter SHALL count forwarded beats; after beat 18, STREAM -> WAIT_RES and grant drops to 0.
REQ-022 WAIT_RES -> DRAIN on the first sub_out_valid.
REQ-023 In DRAIN, each sub_out_valid beat SHALL appear on out_valid/out_diff with 1-cycle registered latency and out_id = served requester.
REQ-024 After 9 result beats, DRAIN -> IDLE.
REQ-025 The earliest new grant SHALL be the cycle after the 9th result is forwarded; the engine is never fed while results are pending.
REQ-026 req dropping during STREAM, WAIT_RES or DRAIN SHALL NOT abort the transaction.
REQ-027 Simultaneous req = 2'b11 in IDLE SHALL be resolved by the RR pointer only.
REQ-028 sub_out_valid in IDLE or STREAM SHALL be ignored: no out_valid.

Reset
REQ-029 On rst_n low, the block SHALL immediately go to IDLE with grant = 0, sub_in_valid = 0, sub_in_image = 0, out_valid = 0, out_diff = 0, out_id = 0, counters = 0 and RR pointer = A.
REQ-030 Reset mid-transaction SHALL discard it; no partial output after release.

Configuration
REQ-031 With macro IMG_SUB_ARB_TIMEOUT_EN defined: in STREAM with zero beats forwarded, if no granted in_valid arrives for TIMEOUT_CYC consecutive cycles, the block SHALL return to IDLE, drop grant, flip the RR pointer and forward nothing.
REQ-032 Without IMG_SUB_ARB_TIMEOUT_EN, STREAM SHALL wait indefinitely and the timeout counter SHALL not exist.
REQ-033 The timeout SHALL never trigger once at least one beat is forwarded.

Structure
REQ-034 Package img_sub_pkg SHALL hold the state enum and the constants IMG_BEATS = 18 and DIFF_BEATS = 9.
REQ-035 The RR grant selection SHALL be a sub-module rr_arb2 (req, pointer -> one-hot grant); everything else stays in img_sub_arb.

Verification
REQ-036 The bench SHALL cover:
- req = 01, A streams 18 beats 1..15,0,1,2 contiguous -> sub_in_* mirrors them 1 cycle later; grant = 01 for exactly the stream duration.
- req = 11 from reset, both stream twice -> grant order A, B, A, B; out_id sequence 0, 1, 0, 1, 9 beats each.
- A streams with 2-cycle gaps after every beat -> exactly 18 sub_in_valid pulses, gaps pass as 0; transition to WAIT_RES after beat 18.
- Engine returns 9 results 4'hF..4'h7 -> out_diff = F..7 with 1-cycle latency, out_id = served requester, then IDLE.
- rst_n low at beat 10 of a stream -> all outputs 0 next edge; a fresh req after release completes normally.
- TIMEOUT_EN, TIMEOUT_CYC = 8, B granted but silent -> grant drops after 8 cycles, next grant goes to A, no out_valid.
